// File: rtl/laser_track_ctrl_pkg.sv
// Shared constants, types and helpers for the laser tracking controller.
// Frame geometry defaults and the coordinate width live here so all files agree.
package laser_track_ctrl_pkg;

    localparam int PIXEL_SIZE  = 32;
    localparam int FRAME_W_DEF = 640;
    localparam int FRAME_H_DEF = 480;
    localparam int DRAIN_DEF   = 2;

    typedef logic [PIXEL_SIZE-1:0] coord_t;

    typedef struct packed {
        logic [31:0] xy;
        logic        found;
    } result_t;

    localparam coord_t COORD_ZERO = {PIXEL_SIZE{1'b0}};
    localparam coord_t COORD_ONE  = {{(PIXEL_SIZE-1){1'b0}}, 1'b1};

    // Increment with wrap to zero once the limit value has been reached.
    function automatic coord_t coord_wrap_inc(input coord_t c, input coord_t lim);
        coord_t r;
        if (c == lim) begin
            r = COORD_ZERO;
        end else begin
            r = c + COORD_ONE;
        end
        return r;
    endfunction

endpackage

// File: rtl/pixel_coord_counter.sv
// Raster x/y position counter: x runs 0..FRAME_W-1, then y advances.
// 'last' flags the final pixel of the frame so the caller can end the scan.
module pixel_coord_counter
    import laser_track_ctrl_pkg::*;
#(
    parameter int FRAME_W = FRAME_W_DEF,
    parameter int FRAME_H = FRAME_H_DEF
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clear,
    input  logic                  step,
    output logic [PIXEL_SIZE-1:0] x,
    output logic [PIXEL_SIZE-1:0] y,
    output logic                  last
);

    localparam coord_t X_MAX = PIXEL_SIZE'(FRAME_W - 1);
    localparam coord_t Y_MAX = PIXEL_SIZE'(FRAME_H - 1);

    coord_t x_r;
    coord_t y_r;
    logic   x_end_s;

    assign x_end_s = (x_r == X_MAX);
    assign last    = x_end_s && (y_r == Y_MAX);
    assign x       = x_r;
    assign y       = y_r;

    // Position registers; clear wins over step.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x_r <= COORD_ZERO;
            y_r <= COORD_ZERO;
        end else if (clear) begin
            x_r <= COORD_ZERO;
            y_r <= COORD_ZERO;
        end else if (step) begin
            x_r <= coord_wrap_inc(x_r, X_MAX);
            if (x_end_s) begin
                y_r <= coord_wrap_inc(y_r, Y_MAX);
            end else begin
                y_r <= y_r;
            end
        end else begin
            x_r <= x_r;
            y_r <= y_r;
        end
    end

endmodule

// File: rtl/laser_track_ctrl.sv
// Frame sequencer for the laser spot detector: clears it, steps the raster
// coordinate through one frame, then captures the detector result after a drain delay.
module laser_track_ctrl
    import laser_track_ctrl_pkg::*;
#(
    parameter int FRAME_W = FRAME_W_DEF,
    parameter int FRAME_H = FRAME_H_DEF,
    parameter int DRAIN   = DRAIN_DEF
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  cont,
    input  logic                  pix_valid,
    input  logic                  pix_sof,
    input  logic [31:0]           det_xy,
    input  logic                  det_found,
    output logic                  det_en,
    output logic                  det_reset_n,
    output logic [PIXEL_SIZE-1:0] x,
    output logic [PIXEL_SIZE-1:0] y,
    output logic [31:0]           result_xy,
    output logic                  result_found,
    output logic                  result_valid,
    input  logic                  result_ack,
    output logic                  busy,
    output logic [15:0]           frame_count,
    output logic                  overflow,
    output logic                  frame_err
);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_CLEAR    = 3'd1;
    localparam logic [2:0] ST_WAIT_SOF = 3'd2;
    localparam logic [2:0] ST_SCAN     = 3'd3;
    localparam logic [2:0] ST_DRAIN    = 3'd4;

    localparam int DRAIN_CW = (DRAIN > 1) ? $clog2(DRAIN) : 1;
    localparam logic [DRAIN_CW-1:0] DRAIN_LAST = DRAIN_CW'(DRAIN - 1);
    localparam logic [DRAIN_CW-1:0] DRAIN_ZERO = {DRAIN_CW{1'b0}};
    localparam logic [DRAIN_CW-1:0] DRAIN_ONE  = {{(DRAIN_CW-1){1'b0}}, 1'b1};

    logic [2:0]          state_r;
    logic [2:0]          state_nxt_s;
    logic [DRAIN_CW-1:0] drain_cnt_r;
    logic                drain_done_s;
    logic                capture_s;
    logic                short_frame_s;
    logic                step_s;
    logic                det_en_s;
    logic                clr_flags_s;
    logic                coord_clear_s;
    logic                coord_last_s;
    result_t             result_r;
    logic                result_valid_r;
    logic [15:0]         frame_count_r;
    logic                overflow_r;
    logic                frame_err_r;

    assign drain_done_s  = (state_r == ST_DRAIN) && (drain_cnt_r == DRAIN_LAST);
    assign coord_clear_s = (state_r == ST_IDLE) || (state_r == ST_CLEAR);

    pixel_coord_counter #(
        .FRAME_W (FRAME_W),
        .FRAME_H (FRAME_H)
    ) u_coord (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (coord_clear_s),
        .step    (step_s),
        .x       (x),
        .y       (y),
        .last    (coord_last_s)
    );

    // Next-state and per-beat control; stop overrides everything else.
    always_comb begin
        state_nxt_s   = state_r;
        capture_s     = 1'b0;
        short_frame_s = 1'b0;
        step_s        = 1'b0;
        det_en_s      = 1'b0;
        clr_flags_s   = 1'b0;
        if (stop) begin
            state_nxt_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_nxt_s = ST_CLEAR;
                        clr_flags_s = 1'b1;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_CLEAR: begin
                    state_nxt_s = ST_WAIT_SOF;
                end
                ST_WAIT_SOF: begin
                    if (pix_valid && pix_sof) begin
                        state_nxt_s = ST_SCAN;
                        step_s      = 1'b1;
                        det_en_s    = 1'b1;
                    end else begin
                        state_nxt_s = ST_WAIT_SOF;
                    end
                end
                ST_SCAN: begin
                    det_en_s = pix_valid;
                    if (pix_valid && pix_sof) begin
                        // A new frame arrived before the last pixel: discard and re-arm.
                        short_frame_s = 1'b1;
                        state_nxt_s   = ST_CLEAR;
                    end else if (pix_valid) begin
                        step_s = 1'b1;
                        if (coord_last_s) begin
                            state_nxt_s = ST_DRAIN;
                        end else begin
                            state_nxt_s = ST_SCAN;
                        end
                    end else begin
                        state_nxt_s = ST_SCAN;
                    end
                end
                ST_DRAIN: begin
                    if (drain_done_s) begin
                        capture_s   = 1'b1;
                        state_nxt_s = cont ? ST_CLEAR : ST_IDLE;
                    end else begin
                        state_nxt_s = ST_DRAIN;
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Drain delay counter, restarted on every entry into DRAIN_ST.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            drain_cnt_r <= DRAIN_ZERO;
        end else if ((state_r == ST_DRAIN) && !drain_done_s) begin
            drain_cnt_r <= drain_cnt_r + DRAIN_ONE;
        end else begin
            drain_cnt_r <= DRAIN_ZERO;
        end
    end

    // Result capture and handshake; a same-cycle ack is consumed by the new capture.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            result_r       <= '{xy: 32'd0, found: 1'b0};
            result_valid_r <= 1'b0;
            frame_count_r  <= 16'd0;
        end else if (capture_s) begin
            result_r       <= '{xy: det_xy, found: det_found};
            result_valid_r <= 1'b1;
            frame_count_r  <= frame_count_r + 16'd1;
        end else if (result_ack) begin
            result_r       <= result_r;
            result_valid_r <= 1'b0;
            frame_count_r  <= frame_count_r;
        end else begin
            result_r       <= result_r;
            result_valid_r <= result_valid_r;
            frame_count_r  <= frame_count_r;
        end
    end

    // Sticky error flags, cleared only by an accepted start.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow_r  <= 1'b0;
            frame_err_r <= 1'b0;
        end else if (clr_flags_s) begin
            overflow_r  <= 1'b0;
            frame_err_r <= 1'b0;
        end else begin
            overflow_r  <= overflow_r | (capture_s & result_valid_r & ~result_ack);
            frame_err_r <= frame_err_r | short_frame_s;
        end
    end

    assign det_en       = det_en_s;
    assign det_reset_n  = reset_n & (state_r != ST_CLEAR);
    assign result_xy    = result_r.xy;
    assign result_found = result_r.found;
    assign result_valid = result_valid_r;
    assign busy         = (state_r != ST_IDLE);
    assign frame_count  = frame_count_r;
    assign overflow     = overflow_r;
    assign frame_err    = frame_err_r;

endmodule

// File: doc/laser_track_ctrl.md
LASER_TRACK_CTRL -- requirements
Module: laser_track_ctrl

Interface
REQ-001 SHALL have parameter FRAME_W, default 640, active pixels per line.
REQ-002 SHALL have parameter FRAME_H, default 480, lines per frame.
REQ-003 SHALL have parameter DRAIN, default 2, cycles from last pixel to result capture.
REQ-004 SHALL have port clk  in  1  single clock; all state on its rising edge.
REQ-005 SHALL have port reset_n  in  1  reset, asynchronous and active-low.
REQ-006 SHALL have port start  in  1  arm pulse; also clears sticky error flags.
REQ-007 SHALL have port stop  in  1  abort to IDLE.
REQ-008 SHALL have port cont  in  1  continuous mode: re-arm after each capture.
REQ-009 SHALL have port pix_valid  in  1  pixel beat valid.
REQ-010 SHALL have port pix_sof  in  1  first pixel of frame; qualified by pix_valid.
REQ-011 SHALL have port det_xy  in  32  detector laser coordinate {x[15:0],y[15:0]}.
REQ-012 SHALL have port det_found  in  1  detector run-found status.
REQ-013 SHALL have port det_en  out  1  detector enable.
REQ-014 SHALL have port det_reset_n  out  1  per-frame detector clear, active-low.
REQ-015 SHALL have ports x and y  out  32 each  coordinate of the current beat.
REQ-016 SHALL have port result_xy  out  32  captured coordinate.
REQ-017 SHALL have port result_found  out  1  captured found flag.
REQ-018 SHALL have ports result_valid  out  1  and result_ack  in  1  forming the result handshake.
REQ-019 SHALL have ports busy  out  1  (state != IDLE), frame_count  out  16  (captures done), overflow  out  1  and frame_err  out  1  (both sticky).

Function
REQ-020 SHALL implement states IDLE, CLEAR, WAIT_SOF, SCAN, DRAIN_ST.
REQ-021 SHALL transition IDLE->CLEAR on start; CLEAR lasts exactly 1 cycle with det_reset_n=0, then goes to WAIT_SOF.
REQ-022 SHALL transition WAIT_SOF->SCAN on pix_valid&pix_sof; that beat SHALL present x=0, y=0 with det_en=1.
REQ-023 SHALL drive det_en=pix_valid in SCAN, 0 elsewhere except the sof beat in REQ-022.
REQ-024 SHALL increment x on each valid beat; at x=FRAME_W-1, x wraps to 0 and y increments.
REQ-025 SHALL transition SCAN->DRAIN_ST on the valid beat with x=FRAME_W-1, y=FRAME_H-1.
REQ-026 SHALL remain in DRAIN_ST for DRAIN cycles, then latch det_xy/det_found into result_*, set result_valid, and increment frame_count (wrapping at 16 bits).
REQ-027 SHALL go after capture to CLEAR if cont=1, else to IDLE.
REQ-028 SHALL clear result_valid on result_ack; result data SHALL hold while result_valid=1.
REQ-029 On a capture while result_valid=1 and no ack, SHALL overwrite result data and set overflow; ack in the same cycle as capture SHALL leave result_valid=1 with no overflow.
REQ-030 SHALL treat pix_valid&pix_sof in SCAN as a short frame: no capture, set frame_err, go to CLEAR.
REQ-031 SHALL ignore pix_valid beats in IDLE/CLEAR/DRAIN_ST; non-sof beats in WAIT_SOF SHALL be ignored.
REQ-032 SHALL send stop from any state to IDLE next cycle with det_en=0; stop and start together SHALL resolve with stop winning.
REQ-033 SHALL ignore start while busy; start in IDLE SHALL clear overflow and frame_err.

Reset
REQ-034 While reset_n=0, all of the following SHALL hold asynchronously: state=IDLE, x=y=0, det_en=0, det_reset_n=0, result_xy=0, result_found=0, result_valid=0, frame_count=0, overflow=0, frame_err=0, busy=0.
REQ-035 After reset release, det_reset_n SHALL be 1 except in CLEAR.

Structure
REQ-036 FRAME_W/FRAME_H defaults and `PIXEL_SIZE SHALL come from global.vh; state encodings SHALL be local parameters.
REQ-037 x/y wrap counting SHALL be one sub-module, pixel_coord_counter (inputs clear, step; outputs x, y, last).

Verification
REQ-038 FRAME_W=8, FRAME_H=4, start, cont=0, 32 valid beats with det_xy=0x00050002, det_found=1 -> result_valid rises DRAIN cycles after last beat, result_xy=0x00050002, frame_count=1, state IDLE.
REQ-039 Same frame with pix_valid toggling every other cycle -> x sequence 0..7 per line, y 0..3, det_en equals pix_valid.
REQ-040 cont=1, two frames, no ack -> second capture sets overflow=1, frame_count=2, exactly one 1-cycle det_reset_n low before each frame.
REQ-041 sof at beat 10 of a frame -> frame_err=1, no capture, CLEAR then waits for next sof.
REQ-042 stop during SCAN at beat 5, and reset_n low mid-frame -> IDLE, det_en=0; all outputs at REQ-034 values while reset_n=0.
